// File: rtl/cache_pkg.sv
// Shared defaults and FSM encoding for the cache line refill engine.
package cache_pkg;

  localparam int CACHE_LEN_DEF = 8;
  localparam int ADDR_L_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/cache_refill.sv
// Byte-serial cache line refill: fetches CACHE_LEN bytes of the missing line
// from memory, assembles them little-endian and writes the line in one strobe.
module cache_refill
  import cache_pkg::*;
#(
  parameter int CACHE_LEN = CACHE_LEN_DEF,
  parameter int ADDR_L    = ADDR_L_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [ADDR_L-1:0]      miss_addr,
  input  logic                   flush,
  output logic                   busy,
  output logic                   mem_req,
  output logic [ADDR_L-1:0]      mem_addr,
  input  logic [7:0]             mem_rdata,
  input  logic                   mem_valid,
  output logic                   fill_we,
  output logic [ADDR_L-1:0]      fill_addr,
  output logic [8*CACHE_LEN-1:0] fill_data
);

  localparam int CW = $clog2(CACHE_LEN);
  localparam int LW = 8 * CACHE_LEN;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [ADDR_L-1:0] base;
  logic [ADDR_L-1:0] fill_addr_q;
  logic [LW-1:0]   line_buf;
  logic [LW-1:0]   line_nxt;
  logic [LW-1:0]   fill_data_q;
  logic            beat_done;
  logic            last_beat;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    fill_we   = 1'b0;
    beat_done = (state == FETCH) && mem_valid;
    last_beat = beat_done && (cnt == CW'(CACHE_LEN - 1));
    line_nxt  = line_buf;
    line_nxt[{cnt, 3'b000} +: 8] = mem_rdata;

    case (state)
      IDLE: begin
        if (miss_req) state_nxt = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        // base is line aligned, so the add never carries past the line, but
        // it still wraps cleanly at the top of the address space.
        mem_addr = base + ADDR_L'(cnt);
        if (flush)          state_nxt = IDLE;
        else if (last_beat) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        fill_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    fill_addr = fill_addr_q;
    fill_data = fill_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      line_buf    <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_req) begin
        base <= {miss_addr[ADDR_L-1:CW], CW'(0)};
        cnt  <= '0;
      end
      // A beat landing in the flush cycle is dropped along with the refill.
      if (beat_done && !flush) begin
        line_buf <= line_nxt;
        cnt      <= cnt + 1'b1;
        if (last_beat) begin
          fill_addr_q <= base;
          fill_data_q <= line_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Scoreboard bench for cache_refill: stimulus queues expected beats and fills,
// independent monitors compare them against what the DUT presents.
module tb_cache_refill;

  localparam int CL = 8;
  localparam int AL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [AL-1:0] miss_addr;
  logic          flush;
  logic          busy;
  logic          mem_req;
  logic [AL-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_valid;
  logic          fill_we;
  logic [AL-1:0] fill_addr;
  logic [8*CL-1:0] fill_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AL-1:0]        beat_q[$];
  logic [AL+8*CL-1:0]   fill_q[$];

  cache_refill #(.CACHE_LEN(CL), .ADDR_L(AL)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .flush(flush), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .fill_we(fill_we),
    .fill_addr(fill_addr), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  // Memory returns the low byte of the requested address.
  assign mem_rdata = mem_addr[7:0];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*CL-1:0] exp_line(input logic [AL-1:0] b);
    logic [8*CL-1:0] l;
    logic [AL-1:0]   a;
    l = '0;
    for (int i = 0; i < CL; i++) begin
      a = b + AL'(i);
      l[8*i +: 8] = a[7:0];
    end
    return l;
  endfunction

  // Monitors sample just before the rising edge, after stimulus has settled.
  always @(negedge clk) begin
    #4;
    if (rst === 1'b1 && mem_req === 1'b1 && mem_valid === 1'b1 && flush === 1'b0) begin
      if (beat_q.size() == 0) check("unexpected_beat", mem_addr, 'x);
      else check("beat_addr", mem_addr, beat_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [AL+8*CL-1:0] e;
    #4;
    if (fill_we === 1'b1) begin
      if (fill_q.size() == 0) check("unexpected_fill", fill_addr, 'x);
      else begin
        e = fill_q.pop_front();
        check("fill_addr", fill_addr, e[AL+8*CL-1:8*CL]);
        check("fill_data", fill_data, e[8*CL-1:0]);
      end
    end
  end

  task automatic do_refill(input logic [AL-1:0] addr, input int stall_beat,
                           input int flush_beat, input int rst_beat,
                           input bit junk, input bit flush_at_miss);
    logic [AL-1:0] base, beat;
    int  lat, stall_n, abort;
    bit  done, stalled_last;
    base = addr & ~AL'(CL - 1);
    lat = 0; stall_n = 0; done = 0; stalled_last = 0;
    abort = (flush_beat >= 0) ? flush_beat : rst_beat;
    for (int i = 0; i < CL; i++)
      if (abort < 0 || i < abort) beat_q.push_back(base + AL'(i));
    if (abort < 0) fill_q.push_back({base, exp_line(base)});

    @(negedge clk); #2;
    miss_req = 1'b1; miss_addr = addr; flush = flush_at_miss; mem_valid = 1'b1;
    @(negedge clk);
    check("busy_after_accept", busy, 1'b1);

    for (int cyc = 0; cyc < 64; cyc++) begin
      if (fill_we === 1'b1) begin done = 1; break; end
      if (stalled_last) begin
        check("stall_addr_held", mem_addr, base + AL'(stall_beat));
        check("stall_req_held", mem_req, 1'b1);
      end
      beat = mem_addr - base;
      #2;
      miss_req = 1'b0; flush = 1'b0; rst = 1'b1; mem_valid = 1'b1; stalled_last = 0;
      if (mem_req && beat == AL'(stall_beat) && stall_n < 3) begin
        mem_valid = 1'b0; stall_n++; stalled_last = 1;
      end
      if (mem_req && beat == AL'(flush_beat)) flush = 1'b1;
      if (mem_req && beat == AL'(rst_beat)) rst = 1'b0;
      if (junk && mem_req && beat == 2) begin miss_req = 1'b1; miss_addr = 32'h0000_5550; end
      @(negedge clk);
      lat++;
      if (flush === 1'b1 && abort >= 0) begin
        check("flush_busy", busy, 1'b0);
        check("flush_mem_req", mem_req, 1'b0);
        check("flush_fill_we", fill_we, 1'b0);
        #2; flush = 1'b0;
        return;
      end
      if (rst === 1'b0 && abort >= 0) begin
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_fill_we", fill_we, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fill_addr", fill_addr, 0);
        check("rst_fill_data", fill_data, 0);
        #2; rst = 1'b1;
        return;
      end
    end
    if (!done) check("fill_timeout", 1'b0, 1'b1);
    check("fill_latency", lat, CL + ((stall_beat >= 0) ? 3 : 0));
    #2;
    if (junk) begin miss_req = 1'b1; miss_addr = 32'h0000_6660; end
    @(negedge clk);
    check("fill_we_one_cycle", fill_we, 1'b0);
    check("idle_after_write", busy, 1'b0);
    #2; miss_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; miss_req = 1'b0; miss_addr = '0; flush = 1'b0; mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_fill_we", fill_we, 1'b0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_fill_addr", fill_addr, 0);
    check("reset_fill_data", fill_data, 0);
    #2; rst = 1'b1;

    do_refill(32'h0000_1235, -1, -1, -1, 0, 0);
    check("hold_fill_addr", fill_addr, 32'h0000_1230);
    check("hold_fill_data", fill_data, 64'h3736_3534_3332_3130);
    do_refill(32'h0000_2040, 4, -1, -1, 0, 0);
    do_refill(32'h0000_3000, -1, 5, -1, 0, 0);
    do_refill(32'h0000_3008, -1, -1, -1, 0, 0);
    do_refill(32'h0000_4010, -1, -1, -1, 1, 0);
    do_refill(32'hFFFF_FFFC, -1, -1, -1, 0, 0);
    check("wrap_fill_data", fill_data, 64'hFFFE_FDFC_FBFA_F9F8);
    do_refill(32'h0000_6000, -1, -1, 3, 0, 0);
    do_refill(32'h0000_6020, -1, -1, -1, 0, 0);
    do_refill(32'h0000_7001, -1, -1, -1, 0, 1);

    repeat (3) @(negedge clk);
    check("beat_q_drained", beat_q.size(), 0);
    check("fill_q_drained", fill_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
